// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package sub_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, bout = borrow out of this bit.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell plus a borrow flip-flop,
// LSB first, WIDTH RUN cycles per operation and a single-cycle done pulse.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             bit_diff
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-2:0] sr;
    logic [WIDTH-1:0] sr_in;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             cell_d;
    logic             cell_bo;
    logic             accept;
    logic             last;

    full_subtractor u_cell (
        .x    (sa[0]),
        .y    (sb[0]),
        .bin  (borrow),
        .d    (cell_d),
        .bout (cell_bo)
    );

    assign accept = start && ((state == S_IDLE) || (state == S_DONE));
    assign last   = (state == S_RUN) && (cnt == CNT_LAST);
    // New bit enters at the MSB; on the last step this is the fully assembled result.
    assign sr_in  = {cell_d, sr};

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (cnt == CNT_LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        bit_diff = 1'b0;
        case (state)
            S_RUN: begin
                busy     = 1'b1;
                bit_diff = cell_d;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa         <= '0;
            sb         <= '0;
            sr         <= '0;
            borrow     <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (accept) begin
            sa     <= a;
            sb     <= b;
            borrow <= bin;
            cnt    <= '0;
        end else if (state == S_RUN) begin
            sa     <= sa >> 1;
            sb     <= sb >> 1;
            sr     <= sr_in[WIDTH-1:1];
            borrow <= cell_bo;
            cnt    <= cnt + 1'b1;
            if (last) begin
                diff       <= sr_in;
                borrow_out <= cell_bo;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised checks of serial_subtractor at WIDTH=8 and WIDTH=16.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start8, start16;
    logic [15:0] a, b;
    logic        bin;

    logic        busy8, done8, bo8, bd8;
    logic [7:0]  diff8;
    logic        busy16, done16, bo16, bd16;
    logic [15:0] diff16;

    logic        use16;
    logic        busy_s, done_s, bo_s, bd_s;
    logic [15:0] diff_s;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a[7:0]), .b(b[7:0]), .bin(bin),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8), .bit_diff(bd8)
    );

    serial_subtractor #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a), .b(b), .bin(bin),
        .busy(busy16), .done(done16), .diff(diff16), .borrow_out(bo16), .bit_diff(bd16)
    );

    assign busy_s = use16 ? busy16 : busy8;
    assign done_s = use16 ? done16 : done8;
    assign bo_s   = use16 ? bo16   : bo8;
    assign bd_s   = use16 ? bd16   : bd8;
    assign diff_s = use16 ? diff16 : {8'h00, diff8};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One complete operation on the selected width, checked against (a-b-bin) mod 2^w.
    task automatic do_op(input int w, input logic [15:0] av, input logic [15:0] bv,
                         input logic bi, input string tag);
        int          mask, di, lat;
        logic [15:0] bits, exp_d;
        logic        exp_b;
        mask  = (w == 8) ? 32'hFF : 32'hFFFF;
        di    = int'(av & 16'(mask)) - int'(bv & 16'(mask)) - int'(bi);
        exp_b = (di < 0);
        exp_d = 16'(di & mask);
        use16 = (w == 16);
        a = av; b = bv; bin = bi;
        if (w == 16) start16 = 1'b1; else start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; start16 = 1'b0;
        bits = '0;
        lat  = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done_s) begin
                lat = c;
                break;
            end
            if (c < 16 && busy_s) bits[c] = bd_s;
        end
        check_val({tag, "_latency"}, 32'(lat), 32'(w));
        check_val({tag, "_diff"}, {16'h0, diff_s}, {16'h0, exp_d});
        check_val({tag, "_borrow"}, {31'h0, bo_s}, {31'h0, exp_b});
        check_val({tag, "_bitseq"}, {16'h0, bits & 16'(mask)}, {16'h0, exp_d});
        check_val({tag, "_busy_at_done"}, {31'h0, busy_s}, 32'h0);
        @(negedge clk);
        check_val({tag, "_done_one_cycle"}, {31'h0, done_s}, 32'h0);
    endtask

    initial begin
        int          ndone, lat;
        logic [7:0]  cap_d;
        logic        cap_b;
        logic [15:0] ra, rb;
        logic        rbi;

        rst_n = 1'b0; start8 = 1'b0; start16 = 1'b0;
        a = '0; b = '0; bin = 1'b0; use16 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy",   {31'h0, busy8}, 32'h0);
        check_val("rst_done",   {31'h0, done8}, 32'h0);
        check_val("rst_diff",   {24'h0, diff8}, 32'h0);
        check_val("rst_borrow", {31'h0, bo8},   32'h0);
        check_val("rst_bitd",   {31'h0, bd8},   32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Directed vectors from the test plan.
        do_op(8, 16'h05, 16'h03, 1'b0, "t5m3");
        do_op(8, 16'h03, 16'h05, 1'b0, "t3m5");
        do_op(8, 16'h00, 16'h00, 1'b1, "t0m0b");
        do_op(8, 16'hFF, 16'h00, 1'b0, "tFFm0");
        do_op(16, 16'h0000, 16'h0001, 1'b0, "w16_0m1");
        do_op(16, 16'h8000, 16'h0001, 1'b0, "w16_8000m1");

        // Start pulsed during RUN must be ignored.
        use16 = 1'b0;
        a = 16'h05; b = 16'h03; bin = 1'b0; start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        repeat (2) @(posedge clk);
        #1 a = 16'h10; b = 16'h01; start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        ndone = 0; cap_d = '0; cap_b = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done8) begin
                ndone++;
                cap_d = diff8;
                cap_b = bo8;
            end
        end
        check_val("ign_ndone",  32'(ndone),       32'd1);
        check_val("ign_diff",   {24'h0, cap_d},  32'h02);
        check_val("ign_borrow", {31'h0, cap_b},  32'h0);

        // Back-to-back: start held high through the DONE cycle.
        @(posedge clk); #1;
        a = 16'h05; b = 16'h03; bin = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        a = 16'h80; b = 16'h01;
        lat = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done8) begin
                lat = c;
                break;
            end
        end
        check_val("b2b_lat1",  32'(lat),        32'd8);
        check_val("b2b_diff1", {24'h0, diff8}, 32'h02);
        @(posedge clk); #1 start8 = 1'b0;
        @(negedge clk);
        check_val("b2b_done_drop", {31'h0, done8}, 32'h0);
        check_val("b2b_busy2",     {31'h0, busy8}, 32'h1);
        lat = -1;
        for (int c = 1; c < 40; c++) begin
            @(negedge clk);
            if (done8) begin
                lat = c;
                break;
            end
        end
        check_val("b2b_lat2",    32'(lat),        32'd8);
        check_val("b2b_diff2",   {24'h0, diff8}, 32'h7F);
        check_val("b2b_borrow2", {31'h0, bo8},   32'h0);
        @(negedge clk);
        check_val("b2b_done_end", {31'h0, done8}, 32'h0);

        // Reset in the middle of a RUN aborts it without a done pulse.
        @(posedge clk); #1;
        a = 16'h05; b = 16'h03; bin = 1'b0; start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("abort_busy",   {31'h0, busy8}, 32'h0);
        check_val("abort_done",   {31'h0, done8}, 32'h0);
        check_val("abort_diff",   {24'h0, diff8}, 32'h0);
        check_val("abort_borrow", {31'h0, bo8},   32'h0);
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        check_val("abort_no_done", 32'(ndone), 32'd0);
        do_op(8, 16'h05, 16'h03, 1'b0, "after_rst");

        // Random sweep on both widths against the arithmetic reference.
        for (int i = 0; i < 1000; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rbi = 1'($urandom);
            do_op(8, ra, rb, rbi, "rand8");
            do_op(16, ra, rb, rbi, "rand16");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
